rot_mem_arbiter: RTL and testbench

ROT_MEM_ARBITER -- requirements
Module: rot_mem_arbiter

---
 rtl/rot_mem_arbiter.sv | 117 +++++++++++
 tb/tb_rot_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rot_mem_arbiter
// Brief  : Shares one burst memory port between 16-word video write bursts
//          and 8-word video read bursts, forcing a write after a run of reads.
// Rev    : 1.0  initial release
// ============================================================================
module rot_mem_arbiter #(
  parameter logic [23:0] BASE_ADDR    = 24'h000000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        vidin_req,
  input  logic        vidin_frame,
  input  logic [9:0]  vidin_row,
  input  logic [9:0]  vidin_col,
  input  logic [15:0] vidin_d,
  output logic        vidin_ack,
  input  logic        vidout_req,
  input  logic        vidout_frame,
  input  logic [9:0]  vidout_row,
  input  logic [9:0]  vidout_col,
  output logic [15:0] vidout_d,
  output logic        vidout_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdat,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdat,
  output logic        busy
);

  localparam int              c_SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
  localparam logic [3:0]      c_WR_LAST    = 4'd15;
  localparam logic [3:0]      c_RD_LAST    = 4'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_word_cnt;
  logic [c_SW-1:0] r_starve_cnt;

  logic        w_starved;
  logic        w_grant_rd;
  logic        w_grant_wr;
  logic        w_last_ack;
  logic [23:0] w_addr;

  // A waiting write wins over a read only once the read run has hit the limit.
  assign w_starved  = vidin_req && (r_starve_cnt == c_STARVE_MAX);
  assign w_grant_rd = vidout_req && !w_starved;
  assign w_grant_wr = vidin_req && !w_grant_rd;
  assign w_last_ack = mem_ack &&
                      (r_word_cnt == ((r_state == WRITE) ? c_WR_LAST : c_RD_LAST));
  assign w_addr     = w_grant_rd
                    ? BASE_ADDR + 24'({vidout_frame, vidout_row, vidout_col})
                    : BASE_ADDR + 24'({vidin_frame, vidin_row, vidin_col});

  assign busy      = (r_state != IDLE);
  assign vidin_ack = (r_state == WRITE) && mem_ack;
  assign mem_wdat  = vidin_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_word_cnt   <= 4'd0;
      r_starve_cnt <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      vidout_d     <= 16'h0000;
      vidout_ack   <= 1'b0;
    end else begin
      vidout_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_rd || w_grant_wr) begin
            r_state    <= w_grant_rd ? READ : WRITE;
            mem_req    <= 1'b1;
            mem_we     <= w_grant_wr;
            mem_addr   <= w_addr;
            r_word_cnt <= 4'd0;
            if (w_grant_wr || !vidin_req)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != c_STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + c_SW'(1);
          end
        end
        WRITE, READ: begin
          if (mem_ack) begin
            r_word_cnt <= r_word_cnt + 4'd1;
            if (r_state == READ) begin
              vidout_d   <= mem_rdat;
              vidout_ack <= 1'b1;
            end
            if (w_last_ack) begin
              mem_req <= 1'b0;
              r_state <= RELEASE;
            end
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rot_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rot_mem_arbiter
// Brief  : Self-checking bench for rot_mem_arbiter with a burst memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rot_mem_arbiter;

  localparam logic [23:0] BASE  = 24'h000000;
  localparam int          LIMIT = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        vidin_req = 1'b0, vidin_frame = 1'b0;
  logic [9:0]  vidin_row = '0, vidin_col = '0;
  logic [15:0] vidin_d = '0;
  logic        vidin_ack;
  logic        vidout_req = 1'b0, vidout_frame = 1'b0;
  logic [9:0]  vidout_row = '0, vidout_col = '0;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdat;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdat = '0;
  logic        busy;

  rot_mem_arbiter #(.BASE_ADDR(BASE), .STARVE_LIMIT(LIMIT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
    .mem_ack(mem_ack), .mem_rdat(mem_rdat), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0, cyc_n = 0;

  // memory model and monitor state
  bit          mem_auto = 1'b1, mem_gap = 1'b0, mem_active = 1'b0, cur_we = 1'b0;
  bit          prev_rd_ack = 1'b0, adv_pending = 1'b0, last_sent = 1'b0, track_gap = 1'b0;
  logic [23:0] cur_addr = '0;
  int          left = 0, rd_idx = 0, falls = 0, fall_cyc = -1;
  int          wack_err = 0, rd_lat_err = 0, hold_err = 0, end_err = 0, gap_err = 0;
  int          wr_acks = 0, rd_acks = 0;
  logic [24:0] got_grant[$], exp_grant[$];
  logic [15:0] got_rd[$], exp_rd[$], got_wr[$], exp_wr[$];

  task automatic clear_stats();
    wack_err = 0; rd_lat_err = 0; hold_err = 0; end_err = 0; gap_err = 0;
    wr_acks = 0; rd_acks = 0; falls = 0; fall_cyc = -1;
    got_grant.delete(); exp_grant.delete();
    got_rd.delete(); exp_rd.delete(); got_wr.delete(); exp_wr.delete();
  endtask

  // One clock: sample registered outputs, act as memory, then sample combinational outputs.
  task automatic cyc();
    @(posedge clk_sys); #1;
    cyc_n++;
    if (adv_pending) begin vidin_d = vidin_d + 16'h0111; adv_pending = 1'b0; end
    if (vidout_ack !== prev_rd_ack) rd_lat_err++;
    if (vidout_ack === 1'b1) got_rd.push_back(vidout_d);
    if (last_sent) begin
      if (mem_req !== 1'b0) end_err++;
      last_sent = 1'b0;
    end
    if (mem_active && mem_req === 1'b1 && {mem_we, mem_addr} !== {cur_we, cur_addr}) hold_err++;
    if (mem_active && mem_req !== 1'b1) begin
      if (left != 0) end_err++;
      mem_active = 1'b0; falls++; fall_cyc = cyc_n;
    end else if (!mem_active && mem_req === 1'b1) begin
      if (track_gap && fall_cyc >= 0 && (cyc_n - fall_cyc) != 2) gap_err++;
      mem_active = 1'b1; cur_we = mem_we; cur_addr = mem_addr;
      left = mem_we ? 16 : 8; rd_idx = 0;
      got_grant.push_back({mem_we, mem_addr});
    end
    prev_rd_ack = 1'b0;
    if (mem_auto) begin
      if (mem_active && left > 0 && !(mem_gap && cyc_n[0])) begin
        mem_ack = 1'b1; mem_rdat = 16'hA000 + 16'(rd_idx);
        rd_idx++; left--; prev_rd_ack = !cur_we; last_sent = (left == 0);
      end else mem_ack = 1'b0;
    end
    #1;
    if (vidin_ack !== (mem_ack && mem_active && cur_we)) wack_err++;
    if (vidin_ack === 1'b1) begin wr_acks++; got_wr.push_back(mem_wdat); adv_pending = 1'b1; end
    if (mem_ack === 1'b1 && mem_active && !cur_we) rd_acks++;
  endtask

  task automatic test_reset();
    vidin_req = 1'b1; vidout_req = 1'b1; mem_ack = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({mem_req, mem_we, busy, vidin_ack, vidout_ack, mem_addr, vidout_d} !== {5'b0, BASE, 16'h0}) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h",
               {mem_req, mem_we, busy, vidin_ack, vidout_ack, mem_addr, vidout_d}, {5'b0, BASE, 16'h0});
    end
    vidin_req = 1'b0; vidout_req = 1'b0; mem_ack = 1'b0;
    reset_n = 1'b1;
    repeat (2) cyc();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b mem_req=%b required=0,0", busy, mem_req);
    end
  endtask

  task automatic test_write();
    int n = 0;
    clear_stats();
    exp_grant.push_back({1'b1, BASE + 24'h101420});
    for (int i = 0; i < 16; i++) exp_wr.push_back(16'h1000 + 16'(i * 16'h0111));
    vidin_d = 16'h1000; vidin_frame = 1'b1; vidin_row = 10'd5; vidin_col = 10'd32;
    vidin_req = 1'b1; mem_gap = 1'b1;
    while (falls == 0 && n < 200) begin
      cyc(); n++;
      if (wr_acks >= 3) vidin_req = 1'b0;
    end
    checks++;
    if (falls == 0) begin failures++; $display("FAIL write_timeout bursts=%0d required=1", falls); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL write_release busy=%b required=1", busy); end
    cyc();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_idle busy=%b required=0", busy); end
    checks++;
    if (got_grant.size() != 1 || got_grant[0] !== exp_grant[0]) begin
      failures++; $display("FAIL write_grant grants=%0d first=%h required=%h", got_grant.size(),
                           (got_grant.size() > 0) ? got_grant[0] : 25'h0, exp_grant[0]);
    end
    checks++;
    if (wr_acks != 16) begin failures++; $display("FAIL write_ack_count got=%0d required=16", wr_acks); end
    while (exp_wr.size() > 0) begin
      logic [15:0] e, g;
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL write_data got=%h required=%h", g, e); end
    end
    checks++;
    if (wack_err + hold_err + end_err != 0) begin
      failures++; $display("FAIL write_protocol ack_err=%0d hold_err=%0d end_err=%0d required=0",
                           wack_err, hold_err, end_err);
    end
    mem_gap = 1'b0;
  endtask

  task automatic test_read(input string tag);
    int n = 0;
    clear_stats();
    exp_grant.push_back({1'b0, BASE + 24'h000808});
    for (int i = 0; i < 8; i++) exp_rd.push_back(16'hA000 + 16'(i));
    vidout_frame = 1'b0; vidout_row = 10'd2; vidout_col = 10'd8; vidout_req = 1'b1;
    cyc();
    vidout_req = 1'b0;
    while (falls == 0 && n < 100) begin cyc(); n++; end
    checks++;
    if (falls == 0) begin failures++; $display("FAIL %s_timeout bursts=%0d required=1", tag, falls); end
    checks++;
    if (got_grant.size() != 1 || got_grant[0] !== exp_grant[0]) begin
      failures++; $display("FAIL %s_grant grants=%0d first=%h required=%h", tag, got_grant.size(),
                           (got_grant.size() > 0) ? got_grant[0] : 25'h0, exp_grant[0]);
    end
    checks++;
    if (got_rd.size() != 8) begin
      failures++; $display("FAIL %s_pulse_count got=%0d required=8", tag, got_rd.size());
    end
    while (exp_rd.size() > 0) begin
      logic [15:0] e, g;
      e = exp_rd.pop_front();
      g = (got_rd.size() > 0) ? got_rd.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s_data got=%h required=%h", tag, g, e); end
    end
    checks++;
    if (rd_lat_err + wack_err + hold_err + end_err != 0) begin
      failures++; $display("FAIL %s_protocol lat_err=%0d wack_err=%0d hold_err=%0d end_err=%0d required=0",
                           tag, rd_lat_err, wack_err, hold_err, end_err);
    end
    repeat (2) cyc();
  endtask

  task automatic test_simultaneous();
    int n = 0;
    clear_stats();
    exp_grant.push_back({1'b0, BASE + 24'h000808});
    exp_grant.push_back({1'b1, BASE + 24'h101420});
    vidin_req = 1'b1; vidout_req = 1'b1;
    cyc();
    vidout_req = 1'b0;
    while (falls < 2 && n < 200) begin
      cyc(); n++;
      if (got_grant.size() >= 2) vidin_req = 1'b0;
    end
    while (exp_grant.size() > 0) begin
      logic [24:0] e, g;
      e = exp_grant.pop_front();
      g = (got_grant.size() > 0) ? got_grant.pop_front() : 25'hx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL simul_grant got=%h required=%h", g, e); end
    end
    checks++;
    if (wack_err != 0) begin failures++; $display("FAIL simul_vidin_ack errors=%0d required=0", wack_err); end
    repeat (2) cyc();
  endtask

  task automatic test_starvation();
    int n = 0;
    clear_stats();
    track_gap = 1'b1;
    vidin_frame = 1'b1; vidin_row = 10'd3; vidin_col = 10'd0;
    vidout_frame = 1'b0; vidout_row = 10'd7; vidout_col = 10'd16;
    for (int i = 0; i < 10; i++)
      exp_grant.push_back(((i % 5) == 4) ? {1'b1, BASE + 24'h100C00} : {1'b0, BASE + 24'h001C10});
    vidin_req = 1'b1; vidout_req = 1'b1;
    while (got_grant.size() < 10 && n < 400) begin cyc(); n++; end
    vidin_req = 1'b0; vidout_req = 1'b0;
    n = 0;
    while (mem_active && n < 100) begin cyc(); n++; end
    while (exp_grant.size() > 0) begin
      logic [24:0] e, g;
      e = exp_grant.pop_front();
      g = (got_grant.size() > 0) ? got_grant.pop_front() : 25'hx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL starve_grant got=%h required=%h", g, e); end
    end
    checks++;
    if (gap_err + end_err + hold_err != 0) begin
      failures++; $display("FAIL starve_protocol gap_err=%0d end_err=%0d hold_err=%0d required=0",
                           gap_err, end_err, hold_err);
    end
    track_gap = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_stray_ack();
    clear_stats();
    mem_auto = 1'b0; mem_ack = 1'b1; mem_rdat = 16'hDEAD;
    repeat (3) cyc();
    mem_ack = 1'b0; mem_auto = 1'b1;
    cyc();
    checks++;
    if (rd_lat_err + wack_err != 0 || got_rd.size() != 0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL stray_ack pulses=%0d busy=%b mem_req=%b required=0,0,0",
                           got_rd.size() + wack_err, busy, mem_req);
    end
    test_read("post_stray");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_stats();
    vidout_frame = 1'b0; vidout_row = 10'd2; vidout_col = 10'd8; vidout_req = 1'b1;
    cyc();
    vidout_req = 1'b0;
    while (rd_acks < 4 && n < 50) begin cyc(); n++; end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || vidout_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid mem_req=%b vidout_ack=%b busy=%b required=0,0,0",
                           mem_req, vidout_ack, busy);
    end
    mem_ack = 1'b0; mem_active = 1'b0; left = 0; last_sent = 1'b0; prev_rd_ack = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    test_read("post_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read("read");
    test_simultaneous();
    test_starvation();
    test_stray_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
